// File: rtl/cv32e40s_lfsr_bank.sv
// Bank of NUM_CH independent LFSR channels stepped together by a multi-step
// shift FSM, with per-channel seed load and all-zero lockup recovery.
module cv32e40s_lfsr_bank #(
   parameter int WIDTH = 32,
   parameter int NUM_CH = 3,
   parameter logic [NUM_CH-1:0][WIDTH-1:0] COEFFS =
      {32'h8000_007A, 32'h8000_0062, 32'h8000_0057},
   parameter logic [NUM_CH-1:0][WIDTH-1:0] DEFAULT_SEEDS =
      {32'hC0FF_EE01, 32'h9ABC_DEF1, 32'h1234_5679},
   parameter bit GALOIS = 1'b0,
   parameter int MAX_STEPS = 8,
   localparam int SW = $clog2(MAX_STEPS + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable_i,
   input  logic [NUM_CH-1:0]         seed_we_i,
   input  logic [WIDTH-1:0]          seed_i,
   input  logic                      shift_req_i,
   input  logic [SW-1:0]             shift_steps_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [NUM_CH*WIDTH-1:0]   data_o,
   output logic [NUM_CH-1:0]         lockup_o,
   output logic [7:0]                lockup_cnt_o
);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_e;

   localparam logic [SW-1:0] MAX_S = SW'(MAX_STEPS);

   state_e                         state_q;
   logic [SW-1:0]                  cnt_q;
   logic                           done_q;
   logic [NUM_CH-1:0][WIDTH-1:0]   ch_q, ch_d;
   logic [NUM_CH-1:0]              recov;
   logic [7:0]                     lockup_cnt_q;
   logic [SW-1:0]                  steps_clamped;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] tap);
      if (GALOIS) begin
         return (q << 1) ^ (q[WIDTH-1] ? tap : '0);
      end else begin
         return {q[WIDTH-2:0], ^(q & tap)};
      end
   endfunction

   assign steps_clamped = (shift_steps_i > MAX_S) ? MAX_S : shift_steps_i;

   // done_q is registered so it lines up with the last busy cycle (cnt_q == 1).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (shift_req_i) begin
                  done_q <= (steps_clamped <= SW'(1));
                  if (steps_clamped != '0) begin
                     state_q <= SHIFT;
                     cnt_q   <= steps_clamped;
                  end
               end
            end
            SHIFT: begin
               cnt_q  <= cnt_q - SW'(1);
               done_q <= (cnt_q == SW'(2));
               if (cnt_q == SW'(1)) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      lockup_o = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         lockup_o[c] = (ch_q[c] == '0) && enable_i;
      end
   end

   always_comb begin
      ch_d  = ch_q;
      recov = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (seed_we_i[c]) begin
            ch_d[c] = seed_i;
         end else if (lockup_o[c]) begin
            ch_d[c]  = DEFAULT_SEEDS[c];
            recov[c] = 1'b1;
         end else if (state_q == SHIFT) begin
            ch_d[c] = lfsr_step(ch_q[c], COEFFS[c]);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_q         <= DEFAULT_SEEDS;
         lockup_cnt_q <= 8'd0;
      end else begin
         ch_q <= ch_d;
         if ((|recov) && (lockup_cnt_q != 8'hFF)) begin
            lockup_cnt_q <= lockup_cnt_q + 8'd1;
         end
      end
   end

   assign busy_o       = (state_q == SHIFT);
   assign done_o       = done_q;
   assign data_o       = ch_q;
   assign lockup_cnt_o = lockup_cnt_q;

endmodule

// File: tb/tb_cv32e40s_lfsr_bank.sv
// Drives a Fibonacci and a Galois instance with shared stimulus and checks
// both against a behavioural model every cycle, plus literal spot checks.
module tb_cv32e40s_lfsr_bank;

   localparam int W  = 8;
   localparam int NC = 3;
   localparam int MS = 8;
   localparam int SW = 4;

   localparam logic [NC-1:0][W-1:0] FIB_C = {8'h8E, 8'hB4, 8'hB8};
   localparam logic [NC-1:0][W-1:0] GAL_C = {8'h2D, 8'h63, 8'h1D};
   localparam logic [NC-1:0][W-1:0] SEEDS = {8'h5A, 8'h3C, 8'hA5};

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            enable = 1'b0;
   logic [NC-1:0]   seed_we = '0;
   logic [W-1:0]    seed = '0;
   logic            req = 1'b0;
   logic [SW-1:0]   steps = '0;

   logic            busy_f, done_f, busy_g, done_g;
   logic [NC*W-1:0] data_f, data_g;
   logic [NC-1:0]   lock_f, lock_g;
   logic [7:0]      lcnt_f, lcnt_g;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   cv32e40s_lfsr_bank #(.WIDTH(W), .NUM_CH(NC), .COEFFS(FIB_C), .DEFAULT_SEEDS(SEEDS),
                        .GALOIS(1'b0), .MAX_STEPS(MS)) u_fib (
      .clk(clk), .rst(rst), .enable_i(enable), .seed_we_i(seed_we), .seed_i(seed),
      .shift_req_i(req), .shift_steps_i(steps), .busy_o(busy_f), .done_o(done_f),
      .data_o(data_f), .lockup_o(lock_f), .lockup_cnt_o(lcnt_f));

   cv32e40s_lfsr_bank #(.WIDTH(W), .NUM_CH(NC), .COEFFS(GAL_C), .DEFAULT_SEEDS(SEEDS),
                        .GALOIS(1'b1), .MAX_STEPS(MS)) u_gal (
      .clk(clk), .rst(rst), .enable_i(enable), .seed_we_i(seed_we), .seed_i(seed),
      .shift_req_i(req), .shift_steps_i(steps), .busy_o(busy_g), .done_o(done_g),
      .data_o(data_g), .lockup_o(lock_g), .lockup_cnt_o(lcnt_g));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   int  m_ch [2][NC];
   int  m_lcnt [2];
   bit  m_busy;
   int  m_rem;
   bit  m_zero;

   function automatic int mstep(input int inst, input int c, input int q);
      int t;
      int sh;
      t  = (inst == 0) ? int'(FIB_C[c]) : int'(GAL_C[c]);
      sh = (q * 2) % 256;
      if (inst == 0) return sh + ($countones(q & t) % 2);
      else           return (q >= 128) ? (sh ^ t) : sh;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < NC; c++) m_ch[i][c] = int'(SEEDS[c]);
            m_lcnt[i] = 0;
         end
         m_busy = 0; m_rem = 0; m_zero = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            bit any;
            any = 0;
            for (int c = 0; c < NC; c++) begin
               if (seed_we[c])                      m_ch[i][c] = int'(seed);
               else if (enable && m_ch[i][c] == 0) begin
                  m_ch[i][c] = int'(SEEDS[c]); any = 1;
               end
               else if (m_busy)                     m_ch[i][c] = mstep(i, c, m_ch[i][c]);
            end
            if (any && m_lcnt[i] < 255) m_lcnt[i]++;
         end
         m_zero = 0;
         if (m_busy) begin
            m_rem--;
            m_busy = (m_rem > 0);
         end else if (req) begin
            int s;
            s = (int'(steps) > MS) ? MS : int'(steps);
            if (s == 0) m_zero = 1;
            else begin m_busy = 1; m_rem = s; end
         end
      end
   end

   always @(negedge clk) begin
      logic [NC*W-1:0] ed [2];
      logic [NC-1:0]   el [2];
      bit              edone;
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < NC; c++) begin
            ed[i][c*W +: W] = W'(m_ch[i][c]);
            el[i][c]        = enable && (m_ch[i][c] == 0);
         end
      end
      edone = (m_busy && m_rem == 1) || m_zero;
      chk("fib_data", data_f, ed[0]);
      chk("gal_data", data_g, ed[1]);
      chk("fib_lockup", lock_f, el[0]);
      chk("gal_lockup", lock_g, el[1]);
      chk("fib_lcnt", lcnt_f, 8'(m_lcnt[0]));
      chk("gal_lcnt", lcnt_g, 8'(m_lcnt[1]));
      chk("fib_busy", busy_f, m_busy);
      chk("gal_busy", busy_g, m_busy);
      chk("fib_done", done_f, edone);
      chk("gal_done", done_g, edone);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int nb, nd;
      logic [NC*W-1:0] snap_f, snap_g;

      #1 rst = 1'b1;
      repeat (3) tick();
      chk("rst_data_f", data_f, 24'h5A3CA5);
      chk("rst_data_g", data_g, 24'h5A3CA5);
      chk("rst_busy", busy_f, 1'b0);
      rst = 1'b0;
      tick();

      // lockup recovery on ch1
      enable = 1'b1; seed_we = 3'b010; seed = 8'h00;
      tick();
      seed_we = '0;
      chk("lk_flag_set", lock_f[1], 1'b1);
      chk("lk_ch1_zero", data_f[15:8], 8'h00);
      tick();
      chk("lk_flag_clr", lock_f[1], 1'b0);
      chk("lk_ch1_seed", data_f[15:8], 8'h3C);
      chk("lk_cnt_f", lcnt_f, 8'd1);
      chk("lk_cnt_g", lcnt_g, 8'd1);

      // Fibonacci 2-step
      seed_we = 3'b001; seed = 8'h01;
      tick();
      seed_we = '0; req = 1'b1; steps = 4'd2;
      tick();
      req = 1'b0;
      chk("f2_busy1", busy_f, 1'b1);
      chk("f2_done1", done_f, 1'b0);
      chk("f2_ch0_a", data_f[7:0], 8'h01);
      tick();
      chk("f2_ch0_b", data_f[7:0], 8'h02);
      chk("f2_done2", done_f, 1'b1);
      tick();
      chk("f2_idle", busy_f, 1'b0);
      chk("f2_ch0_c", data_f[7:0], 8'h04);
      chk("f2_g_ch0", data_g[7:0], 8'h04);

      // Galois single step from 0x80
      seed_we = 3'b001; seed = 8'h80;
      tick();
      seed_we = '0; req = 1'b1; steps = 4'd1;
      tick();
      req = 1'b0;
      chk("g1_done", done_g, 1'b1);
      tick();
      chk("g1_ch0", data_g[7:0], 8'h1D);
      chk("g1_f_ch0", data_f[7:0], 8'h01);

      // clamp to MAX_STEPS, extra requests ignored while busy
      req = 1'b1; steps = 4'd15;
      tick();
      steps = 4'd3;
      nb = 0; nd = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 4) req = 1'b0;
         if (busy_f) nb++;
         if (done_f) nd++;
         tick();
      end
      chk("clamp_busy_cycles", nb, 8);
      chk("clamp_done_count", nd, 1);

      // zero-step request
      snap_f = data_f; snap_g = data_g;
      req = 1'b1; steps = 4'd0;
      tick();
      req = 1'b0;
      chk("z_done", done_f, 1'b1);
      chk("z_busy", busy_f, 1'b0);
      chk("z_data_f", data_f, snap_f);
      chk("z_data_g", data_g, snap_g);
      tick();
      chk("z_done_clr", done_f, 1'b0);

      // zero channel with detection disabled holds zero
      enable = 1'b0; seed_we = 3'b001; seed = 8'h00;
      tick();
      seed_we = '0; req = 1'b1; steps = 4'd3;
      tick();
      req = 1'b0;
      repeat (4) tick();
      chk("dis_ch0_f", data_f[7:0], 8'h00);
      chk("dis_ch0_g", data_g[7:0], 8'h00);
      chk("dis_lock", lock_f[0], 1'b0);
      enable = 1'b1;
      repeat (2) tick();

      // reset in the 2nd of 4 shift cycles
      req = 1'b1; steps = 4'd4;
      tick();
      req = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("mr_busy", busy_f, 1'b0);
      chk("mr_done", done_f, 1'b0);
      chk("mr_data_f", data_f, 24'h5A3CA5);
      chk("mr_data_g", data_g, 24'h5A3CA5);
      tick();
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 5; i++) begin
         if (done_f || done_g) nd++;
         tick();
      end
      chk("mr_no_done", nd, 0);

      // randomized traffic
      repeat (400) begin
         seed_we = ($urandom_range(0, 5) == 0) ? NC'($urandom_range(1, 7)) : '0;
         seed    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         req     = 1'($urandom_range(0, 1));
         steps   = 4'($urandom_range(0, 15));
         enable  = ($urandom_range(0, 3) != 0);
         tick();
      end
      seed_we = '0; req = 1'b0;
      repeat (12) tick();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/cv32e40s_lfsr_bank.md
CV32E40S_LFSR_BANK -- requirements
Module: cv32e40s_lfsr_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of each LFSR channel, legal range 4..64.
REQ-002 SHALL have parameter NUM_CH, default 3: number of independent LFSR channels, legal range 1..8.
REQ-003 SHALL have parameter COEFFS, default three 32-bit CV32E40S default tap masks: per-channel feedback tap mask, NUM_CH x WIDTH.
REQ-004 SHALL have parameter DEFAULT_SEEDS, default three distinct non-zero 32-bit values: per-channel reset and lockup-recovery seed, NUM_CH x WIDTH, each non-zero.
REQ-005 SHALL have parameter GALOIS, default 0: 0 selects Fibonacci update, 1 selects Galois update, applied to all channels.
REQ-006 SHALL have parameter MAX_STEPS, default 8: maximum steps per shift request, legal range 1..255; SW = $clog2(MAX_STEPS+1).
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port enable_i, input, 1 bit: enables lockup detection.
REQ-010 SHALL have port seed_we_i, input, NUM_CH bits: per-channel seed write strobe.
REQ-011 SHALL have port seed_i, input, WIDTH bits: seed value shared by all channels.
REQ-012 SHALL have port shift_req_i, input, 1 bit: multi-step shift request.
REQ-013 SHALL have port shift_steps_i, input, SW bits: step count, sampled with shift_req_i.
REQ-014 SHALL have port busy_o, output, 1 bit: high while in SHIFT state.
REQ-015 SHALL have port done_o, output, 1 bit: single-cycle request-completion pulse.
REQ-016 SHALL have port data_o, output, NUM_CH*WIDTH bits: channel c state on bits [c*WIDTH +: WIDTH].
REQ-017 SHALL have port lockup_o, output, NUM_CH bits: per-channel lockup flag.
REQ-018 SHALL have port lockup_cnt_o, output, 8 bits: saturating count of lockup-recovery cycles.

Function
REQ-019 SHALL use Fibonacci step when GALOIS=0: next = {q[WIDTH-2:0], ^(q & COEFFS[c])}.
REQ-020 SHALL use Galois step when GALOIS=1: next = (q << 1) XOR (q[WIDTH-1] ? COEFFS[c] : 0), truncated to WIDTH bits.
REQ-021 SHALL implement two FSM states, IDLE and SHIFT; busy_o = (state == SHIFT).
REQ-022 SHALL, in IDLE with shift_req_i=1 and clamped steps S>0, load the step counter with S and enter SHIFT next cycle; S = min(shift_steps_i, MAX_STEPS).
REQ-023 SHALL, in IDLE with shift_req_i=1 and S=0, remain in IDLE, shift no channel, and assert done_o in the following cycle.
REQ-024 SHALL, in each SHIFT cycle, advance every channel by exactly one step and decrement the counter; no channel steps in IDLE.
REQ-025 SHALL assert done_o in the SHIFT cycle where counter==1 and return to IDLE next cycle, so S steps take exactly S busy cycles.
REQ-026 SHALL ignore shift_req_i while in SHIFT (no queuing), including in the done_o cycle.
REQ-027 SHALL give per-channel update priority: seed_we_i[c], then lockup recovery, then shift step, then hold.
REQ-028 SHALL, on a seed write during SHIFT, load seed_i into that channel that cycle, consume the step without stepping it, and continue stepping it from the seed on later SHIFT cycles.
REQ-029 SHALL drive lockup_o[c] combinationally as (channel c == 0) AND enable_i.
REQ-030 SHALL load DEFAULT_SEEDS[c] into channel c on the next clock whenever lockup_o[c]=1 and seed_we_i[c]=0, in either FSM state.
REQ-031 SHALL increment lockup_cnt_o by one per cycle with any recovery reload, saturating at 255.
REQ-032 SHALL NOT detect lockup or reload while enable_i=0; a zero channel then holds zero under shifting.
REQ-033 SHALL have no path from seed_i to data_o within the same cycle.

Reset
REQ-034 SHALL, while rst=1, asynchronously force channels to DEFAULT_SEEDS, FSM to IDLE, counter to 0, lockup_cnt_o to 0, busy_o=0 and done_o=0.
REQ-035 SHALL, on reset asserted mid-SHIFT, abort the request without a done_o pulse.

Verification
REQ-036 SHALL be verified with WIDTH=8, GALOIS=0, COEFFS[0]=0xB8, seed 0x01, req S=2: ch0 goes 0x01->0x02->0x04, busy_o for 2 cycles, done_o in the 2nd.
REQ-037 SHALL be verified with GALOIS=1, COEFFS[0]=0x1D, seed 0x80, S=1: ch0=0x1D after the step.
REQ-038 SHALL be verified with enable_i=1 and seed 0x00 written to ch1: lockup_o[1]=1 for one cycle, ch1=DEFAULT_SEEDS[1] next cycle, lockup_cnt_o=1.
REQ-039 SHALL be verified with shift_steps_i=15 and MAX_STEPS=8: exactly 8 busy cycles and one done_o; a second req while busy is ignored.
REQ-040 SHALL be verified with S=0: no state change and done_o one cycle later; enable_i=0 with ch0=0 and S=3 leaves ch0=0 and lockup_o=0.
REQ-041 SHALL be verified with rst asserted in the 2nd of 4 SHIFT cycles: all channels reset to DEFAULT_SEEDS, busy_o=0 and no done_o.
